// File: rtl/uart_tx_fifo_feeder_pkg.sv
// Shared definitions for the UART transmit FIFO feeder: FSM state codes and default sizing.
package uart_tx_fifo_feeder_pkg;

  localparam int DEFAULT_DATA_BIT        = 8;
  localparam int DEFAULT_FIFO_ADDR_WIDTH = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LOAD      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous byte FIFO with extended pointers, flush and a sticky overflow flag.
module uart_sync_fifo #(
  parameter int DATA_BIT   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_BIT-1:0]   wr_data,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  ovf_clr,
  output logic [DATA_BIT-1:0]   rd_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int                DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] PTR_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_BIT-1:0]  mem [0:DEPTH-1];
  logic [ADDR_WIDTH:0]  wr_ptr;
  logic [ADDR_WIDTH:0]  rd_ptr;
  logic                 pop;
  logic                 push;
  logic                 wr_drop;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];

  // A write into a full FIFO is still taken when the head leaves in the same cycle.
  assign pop     = rd_en & ~empty & ~flush;
  assign push    = wr_en & ~flush & (~full | pop);
  assign wr_drop = wr_en & ~flush & full & ~pop;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (flush) begin
        rd_ptr <= wr_ptr;
      end else if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (wr_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_tx_fifo_feeder.sv
// Feeds queued host bytes to the UART transmitter one frame at a time.
//  state        | meaning
//  ST_IDLE      | no frame in flight, waiting for data and feed_en
//  ST_LOAD      | tx_te pulse, tx_dr holds the popped byte
//  ST_WAIT_DONE | frame in flight, waiting for tx_done
module uart_tx_fifo_feeder
  import uart_tx_fifo_feeder_pkg::*;
#(
  parameter int DATA_BIT        = DEFAULT_DATA_BIT,
  parameter int FIFO_ADDR_WIDTH = DEFAULT_FIFO_ADDR_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [DATA_BIT-1:0]        wr_data,
  input  logic                       feed_en,
  input  logic                       flush,
  input  logic                       ovf_clr,
  input  logic                       tx_done,
  output logic                       tx_te,
  output logic [7:0]                 tx_dr,
  output logic [FIFO_ADDR_WIDTH:0]   fifo_level,
  output logic                       fifo_empty,
  output logic                       fifo_full,
  output logic                       overflow,
  output logic                       busy
);

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic                 can_start;
  logic                 frame_pop;
  logic [DATA_BIT-1:0]  fifo_head;
  logic [7:0]           head_byte;

  uart_sync_fifo #(
    .DATA_BIT   (DATA_BIT),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (frame_pop),
    .flush    (flush),
    .ovf_clr  (ovf_clr),
    .rd_data  (fifo_head),
    .level    (fifo_level),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

  assign head_byte = 8'(fifo_head);
  assign can_start = feed_en & ~fifo_empty & ~flush;
  assign busy      = (state != ST_IDLE);

  always_comb begin
    next_state = state;
    frame_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_start) begin
          frame_pop  = 1'b1;
          next_state = ST_LOAD;
        end
      end
      ST_LOAD: begin
        next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          if (can_start) begin
            frame_pop  = 1'b1;
            next_state = ST_LOAD;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // tx_te is registered off the pop so it is high exactly while the FSM sits in LOAD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      tx_te <= 1'b0;
      tx_dr <= 8'd0;
    end else begin
      state <= next_state;
      tx_te <= frame_pop;
      if (frame_pop) begin
        tx_dr <= head_byte;
      end
    end
  end

endmodule
